// File: rtl/quadrant_restore_if.sv
// Handshake bundle for the quadrant restore stage: reduced-angle input,
// trig-core request/response, and final signed sin/cos output.
interface quadrant_restore_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_angle;
  logic [1:0]            in_quadrant;

  logic                  core_req_valid;
  logic                  core_req_ready;
  logic [DATA_WIDTH-1:0] core_ref_angle;

  logic                  core_rsp_valid;
  logic                  core_rsp_ready;
  logic [DATA_WIDTH-1:0] core_rsp_sin;
  logic [DATA_WIDTH-1:0] core_rsp_cos;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_sin;
  logic [DATA_WIDTH-1:0] out_cos;

  // Environment side: produces angles, plays the trig core, consumes results.
  modport master (
    output in_valid, in_angle, in_quadrant,
    input  in_ready,
    input  core_req_valid, core_ref_angle,
    output core_req_ready,
    output core_rsp_valid, core_rsp_sin, core_rsp_cos,
    input  core_rsp_ready,
    input  out_valid, out_sin, out_cos,
    output out_ready
  );

  // Block side.
  modport slave (
    input  in_valid, in_angle, in_quadrant,
    output in_ready,
    output core_req_valid, core_ref_angle,
    input  core_req_ready,
    input  core_rsp_valid, core_rsp_sin, core_rsp_cos,
    output core_rsp_ready,
    output out_valid, out_sin, out_cos,
    input  out_ready
  );
endinterface

// File: rtl/quadrant_restore.sv
// Return path of range reduction: folds a reduced angle into the first
// quadrant for the trig core, remembers the quadrant in an in-order tag
// FIFO, and re-applies the quadrant signs to the core's sin/cos results.
module quadrant_restore #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  quadrant_restore_if.slave bus,
  output logic              busy,
  output logic              err_orphan
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MAG_W = DATA_WIDTH - 1;

  logic                  req_valid_q;
  logic [DATA_WIDTH-1:0] ref_angle_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_sin_q;
  logic [DATA_WIDTH-1:0] out_cos_q;
  logic                  err_orphan_q;

  logic [1:0]            tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      tag_cnt_q;

  logic                  tag_full;
  logic                  tag_empty;
  logic                  in_fire;
  logic                  rsp_fire;
  logic                  tag_push;
  logic                  tag_pop;
  logic                  orphan;
  logic [1:0]            head_tag;
  logic                  sin_neg;
  logic                  cos_neg;
  logic [DATA_WIDTH-1:0] ref_angle_d;
  logic [DATA_WIDTH-1:0] sin_d;
  logic [DATA_WIDTH-1:0] cos_d;

  // Flip the sign bit on request, but never let a zero magnitude become -0.
  function automatic logic [DATA_WIDTH-1:0] apply_sign(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  neg
  );
    logic [MAG_W-1:0] mag;
    mag = v[MAG_W-1:0];
    if (mag == '0) return '0;
    return {v[DATA_WIDTH-1] ^ neg, mag};
  endfunction

  assign tag_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_cnt_q == '0);

  assign bus.in_ready       = !tag_full && (!req_valid_q || bus.core_req_ready);
  assign bus.core_rsp_ready = tag_empty || !out_valid_q || bus.out_ready;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign rsp_fire = bus.core_rsp_valid && bus.core_rsp_ready;
  assign tag_push = in_fire;
  assign tag_pop  = rsp_fire && !tag_empty;
  assign orphan   = rsp_fire && tag_empty;

  // Quadrant 2/3 have negative sine, quadrant 1/2 negative cosine.
  assign head_tag = tag_mem[rd_ptr_q];
  assign sin_neg  = head_tag[1];
  assign cos_neg  = head_tag[1] ^ head_tag[0];
  assign sin_d    = apply_sign(bus.core_rsp_sin, sin_neg);
  assign cos_d    = apply_sign(bus.core_rsp_cos, cos_neg);

  // Fold the reduced angle to its first-quadrant reference; quadrant is trusted.
  always_comb begin
    ref_angle_d = bus.in_angle;
    case (bus.in_quadrant)
      2'd0:    ref_angle_d = bus.in_angle;
      2'd1:    ref_angle_d = DATA_WIDTH'(180) - bus.in_angle;
      2'd2:    ref_angle_d = bus.in_angle - DATA_WIDTH'(180);
      default: ref_angle_d = DATA_WIDTH'(360) - bus.in_angle;
    endcase
  end

  // Tag storage; contents are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[wr_ptr_q] <= bus.in_quadrant;
  end

  // Request register, tag FIFO pointers, result register and orphan flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q  <= 1'b0;
      ref_angle_q  <= '0;
      out_valid_q  <= 1'b0;
      out_sin_q    <= '0;
      out_cos_q    <= '0;
      err_orphan_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_cnt_q    <= '0;
    end else begin
      if (in_fire) begin
        req_valid_q <= 1'b1;
        ref_angle_q <= ref_angle_d;
      end else if (bus.core_req_ready) begin
        req_valid_q <= 1'b0;
      end

      if (tag_pop) begin
        out_valid_q <= 1'b1;
        out_sin_q   <= sin_d;
        out_cos_q   <= cos_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (orphan) err_orphan_q <= 1'b1;

      if (tag_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (tag_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + CNT_W'(1);
        2'b01:   tag_cnt_q <= tag_cnt_q - CNT_W'(1);
        default: tag_cnt_q <= tag_cnt_q;
      endcase
    end
  end

  assign bus.core_req_valid = req_valid_q;
  assign bus.core_ref_angle = ref_angle_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_sin        = out_sin_q;
  assign bus.out_cos        = out_cos_q;
  assign err_orphan         = err_orphan_q;
  assign busy               = !tag_empty || req_valid_q || out_valid_q;

endmodule

// File: tb/tb_quadrant_restore.sv
// Bench for quadrant_restore: directed steps, trig-core model with a small
// sin/cos table, and queues of expected reference angles and final results.
module tb_quadrant_restore;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic err_orphan;

  quadrant_restore_if #(.DATA_WIDTH(DW)) bus ();

  quadrant_restore #(.DATA_WIDTH(DW), .TAG_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int steps    = 0;

  logic [DW-1:0] exp_ref_q [$];
  logic [DW-1:0] exp_sin_q [$];
  logic [DW-1:0] exp_cos_q [$];
  logic [DW-1:0] pending_q [$];

  bit            core_en;
  bit            in_fire;
  bit            rsp_fire_mdl;
  logic          mdl_valid;
  logic [DW-1:0] mdl_sin;
  logic [DW-1:0] mdl_cos;
  logic          orph_valid;

  assign bus.core_rsp_valid = mdl_valid | orph_valid;
  assign bus.core_rsp_sin   = orph_valid ? 64'h4000_0000_0000_0000 : mdl_sin;
  assign bus.core_rsp_cos   = orph_valid ? 64'h4008_0000_0000_0000 : mdl_cos;

  function automatic logic [DW-1:0] lut_sin(input logic [DW-1:0] r);
    case (r)
      64'd0:   return 64'h0000_0000_0000_0000;
      64'd30:  return 64'h3FE0_0000_0000_0000;
      64'd45:  return 64'h3FE6_A09E_667F_3BCD;
      64'd60:  return 64'h3FEB_B67A_E858_4CAA;
      64'd90:  return 64'h3FF0_0000_0000_0000;
      default: return 64'h3F00_0000_0000_0000 | r;
    endcase
  endfunction

  function automatic logic [DW-1:0] lut_cos(input logic [DW-1:0] r);
    case (r)
      64'd0:   return 64'h3FF0_0000_0000_0000;
      64'd30:  return 64'h3FEB_B67A_E858_4CAA;
      64'd45:  return 64'h3FE6_A09E_667F_3BCD;
      64'd60:  return 64'h3FE0_0000_0000_0000;
      64'd90:  return 64'h0000_0000_0000_0000;
      default: return 64'h3E00_0000_0000_0000 | r;
    endcase
  endfunction

  function automatic logic [DW-1:0] fold_ref(input logic [DW-1:0] a, input logic [1:0] q);
    case (q)
      2'd0:    return a;
      2'd1:    return 64'd180 - a;
      2'd2:    return a - 64'd180;
      default: return 64'd360 - a;
    endcase
  endfunction

  function automatic logic [DW-1:0] with_sign(input logic [DW-1:0] v, input bit neg);
    logic [DW-1:0] r;
    r = v;
    if (neg) r[DW-1] = ~r[DW-1];
    if (r[DW-2:0] == '0) r = '0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then update the core model after the rising edge.
  task automatic step();
    logic [DW-1:0] r;
    @(negedge clk);
    in_fire      = !reset && bus.in_valid && bus.in_ready;
    rsp_fire_mdl = !reset && mdl_valid && bus.core_rsp_ready;
    if (in_fire) begin
      r = fold_ref(bus.in_angle, bus.in_quadrant);
      exp_ref_q.push_back(r);
      exp_sin_q.push_back(with_sign(lut_sin(r), bus.in_quadrant inside {2'd2, 2'd3}));
      exp_cos_q.push_back(with_sign(lut_cos(r), bus.in_quadrant inside {2'd1, 2'd2}));
    end
    if (!reset && bus.core_req_valid && bus.core_req_ready) begin
      check1("req_expected", exp_ref_q.size() != 0, 1'b1);
      if (exp_ref_q.size() != 0) begin
        r = exp_ref_q.pop_front();
        check("core_ref_angle", bus.core_ref_angle, r);
        pending_q.push_back(r);
      end
    end
    if (!reset && bus.out_valid && bus.out_ready) begin
      check1("out_expected", exp_sin_q.size() != 0, 1'b1);
      if (exp_sin_q.size() != 0) begin
        check("out_sin", bus.out_sin, exp_sin_q.pop_front());
        check("out_cos", bus.out_cos, exp_cos_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    steps++;
    if (rsp_fire_mdl) begin
      mdl_valid = 1'b0;
      if (pending_q.size() != 0) void'(pending_q.pop_front());
    end
    if (core_en && !reset && !mdl_valid && pending_q.size() != 0) begin
      mdl_valid = 1'b1;
      mdl_sin   = lut_sin(pending_q[0]);
      mdl_cos   = lut_cos(pending_q[0]);
    end
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [1:0] q);
    int n;
    n = 0;
    bus.in_valid    = 1'b1;
    bus.in_angle    = a;
    bus.in_quadrant = q;
    do begin
      step();
      n++;
    end while (!in_fire && n < 50);
    check1("send_accept", in_fire, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_sin_q.size() != 0 || exp_ref_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    check1("drain_done", exp_sin_q.size() == 0, 1'b1);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    mdl_valid    = 1'b0;
    orph_valid   = 1'b0;
    exp_ref_q.delete();
    exp_sin_q.delete();
    exp_cos_q.delete();
    pending_q.delete();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int n;
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_angle       = '0;
    bus.in_quadrant    = 2'd0;
    bus.core_req_ready = 1'b0;
    bus.out_ready      = 1'b0;
    mdl_valid          = 1'b0;
    mdl_sin            = '0;
    mdl_cos            = '0;
    orph_valid         = 1'b0;
    core_en            = 1'b0;

    // Reset state
    step();
    step();
    check1("rst_core_req_valid", bus.core_req_valid, 1'b0);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err_orphan", err_orphan, 1'b0);
    check("rst_core_ref_angle", bus.core_ref_angle, 64'd0);
    check("rst_out_sin", bus.out_sin, 64'd0);
    check("rst_out_cos", bus.out_cos, 64'd0);
    check1("rst_in_ready", bus.in_ready, 1'b1);
    reset = 1'b0;

    // One angle per quadrant, back to back with everything ready
    core_en            = 1'b1;
    bus.core_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    s0 = steps;
    send(64'd30, 2'd0);
    send(64'd150, 2'd1);
    send(64'd210, 2'd2);
    send(64'd330, 2'd3);
    check("throughput_cycles", DW'(steps - s0), 64'd4);
    drain();

    // Axis boundaries, including the would-be negative zeros
    send(64'd0, 2'd0);
    send(64'd90, 2'd0);
    send(64'd180, 2'd1);
    send(64'd270, 2'd2);
    drain();

    // Tag FIFO full: core silent, fifth input blocked
    core_en = 1'b0;
    send(64'd45, 2'd0);
    send(64'd100, 2'd1);
    send(64'd200, 2'd2);
    send(64'd300, 2'd3);
    bus.in_valid    = 1'b1;
    bus.in_angle    = 64'd10;
    bus.in_quadrant = 2'd0;
    step();
    step();
    check1("full_in_ready", bus.in_ready, 1'b0);
    check1("full_no_fire", in_fire, 1'b0);
    check1("full_busy", busy, 1'b1);
    core_en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!in_fire && n < 20);
    check1("full_reaccept", in_fire, 1'b1);
    check("full_reaccept_cycles", DW'(n), 64'd3);
    bus.in_valid = 1'b0;
    drain();

    // Output back-pressure with two responses outstanding
    bus.out_ready = 1'b0;
    send(64'd135, 2'd1);
    send(64'd300, 2'd3);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    step();
    step();
    step();
    check1("bp_out_valid", bus.out_valid, 1'b1);
    check1("bp_rsp_ready", bus.core_rsp_ready, 1'b0);
    check("bp_out_sin_hold", bus.out_sin, 64'h3FE6_A09E_667F_3BCD);
    check("bp_out_cos_hold", bus.out_cos, 64'hBFE6_A09E_667F_3BCD);
    bus.out_ready = 1'b1;
    drain();

    // Orphan response with nothing in flight
    step();
    check1("idle_busy", busy, 1'b0);
    orph_valid = 1'b1;
    step();
    orph_valid = 1'b0;
    check1("orphan_set", err_orphan, 1'b1);
    check1("orphan_no_out", bus.out_valid, 1'b0);
    step();
    step();
    step();
    check1("orphan_sticky", err_orphan, 1'b1);
    check1("orphan_still_no_out", bus.out_valid, 1'b0);
    do_reset();
    check1("orphan_cleared", err_orphan, 1'b0);
    reset = 1'b0;

    // Reset with three requests in flight discards them
    core_en = 1'b0;
    send(64'd30, 2'd0);
    send(64'd150, 2'd1);
    send(64'd210, 2'd2);
    do_reset();
    check1("flush_busy", busy, 1'b0);
    check1("flush_out_valid", bus.out_valid, 1'b0);
    check1("flush_core_req_valid", bus.core_req_valid, 1'b0);
    check1("flush_in_ready", bus.in_ready, 1'b1);
    reset   = 1'b0;
    core_en = 1'b1;
    send(64'd330, 2'd3);
    drain();
    step();
    check1("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
